// File: rtl/aether_burst_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : aether_burst_mem_if
//  Purpose  : Command and data-path bundle between the Aether sequencer and
//             aether_burst_mem.
//  Ports    : command_i / start_address_i / end_address_i  - burst command
//             cmd_ready_o / cmd_error_o                    - command status
//             data_write_*                                  - write beats
//             data_read_*                                   - read beats
//             task_finished_o / mem_running_o               - task status
//             assert_on_i                                   - assertion enable
//  Revision : 1.0 - initial release
// ============================================================================
interface aether_burst_mem_if #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 16
);
    logic [1:0]           command_i;
    logic [AddrWidth-1:0] start_address_i;
    logic [AddrWidth-1:0] end_address_i;
    logic                 cmd_ready_o;
    logic                 cmd_error_o;
    logic [DataWidth-1:0] data_write_i;
    logic                 data_write_valid_i;
    logic                 data_write_ready_o;
    logic [DataWidth-1:0] data_read_o;
    logic                 data_read_valid_o;
    logic                 data_read_ready_i;
    logic                 task_finished_o;
    logic                 mem_running_o;
    logic                 assert_on_i;

    // The memory block itself
    modport slave (
        input  command_i, start_address_i, end_address_i,
        input  data_write_i, data_write_valid_i, data_read_ready_i, assert_on_i,
        output cmd_ready_o, cmd_error_o, data_write_ready_o,
        output data_read_o, data_read_valid_o, task_finished_o, mem_running_o
    );

    // The sequencer driving it
    modport master (
        output command_i, start_address_i, end_address_i,
        output data_write_i, data_write_valid_i, data_read_ready_i, assert_on_i,
        input  cmd_ready_o, cmd_error_o, data_write_ready_o,
        input  data_read_o, data_read_valid_o, task_finished_o, mem_running_o
    );
endinterface
`default_nettype wire

// File: rtl/aether_burst_mem.sv
`default_nettype none
// ============================================================================
//  Module   : aether_burst_mem
//  Purpose  : BRAM-backed burst memory with IDLE/WRITE/READ command model,
//             valid/ready handshakes on both data paths, a configurable read
//             pipeline and a credit-controlled output FIFO.
//  Ports    : clk_i  - clock
//             rst_i  - synchronous active-high reset (memory contents kept)
//             bus    - aether_burst_mem_if.slave (command, write, read, status)
//  Revision : 1.0 - initial release
// ============================================================================
module aether_burst_mem #(
    parameter int DataWidth   = 16,
    parameter int AddrWidth   = 16,
    parameter int ReadLatency = 2
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    aether_burst_mem_if.slave  bus
);

    // Output FIFO holds every read that may be in flight, so it never overflows
    localparam int c_fifo_depth = ReadLatency + 2;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_write = 3'd1;
    localparam logic [2:0] c_st_read  = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    localparam logic [1:0] c_cmd_write = 2'd1;
    localparam logic [1:0] c_cmd_read  = 2'd2;
    localparam logic [1:0] c_cmd_rsvd  = 2'd3;

    logic [2:0]           r_state;
    logic [AddrWidth-1:0] r_addr;
    logic [AddrWidth-1:0] r_end;
    logic                 r_cmd_error;

    logic [DataWidth-1:0] r_mem  [2**AddrWidth];
    // Storage is sized to the pointer range; only c_fifo_depth entries are used
    logic [DataWidth-1:0] r_fifo [8];
    logic [2:0]           r_wr_ptr;
    logic [2:0]           r_rd_ptr;
    logic [2:0]           r_count;
    logic [2:0]           r_outstanding;

    logic                 w_last;
    logic                 w_wr_beat;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic [3:0]           w_credit_used;
    logic [DataWidth-1:0] w_mem_rdata;
    logic [DataWidth-1:0] w_push_data;

    function automatic logic [2:0] f_next(input logic [2:0] p);
        return (p == 3'(c_fifo_depth - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    assign w_last        = (r_addr == r_end);
    assign w_wr_beat     = (r_state == c_st_write) && bus.data_write_valid_i;
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_count};
    // Issue only while every in-flight read is guaranteed a FIFO slot
    assign w_issue       = (r_state == c_st_read) && (w_credit_used < 4'(c_fifo_depth));
    assign w_pop         = (r_count != 3'd0) && bus.data_read_ready_i;
    assign w_mem_rdata   = r_mem[r_addr];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_st_idle;
            r_addr      <= '0;
            r_end       <= '0;
            r_cmd_error <= 1'b0;
        end else begin
            r_cmd_error <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.command_i == c_cmd_write || bus.command_i == c_cmd_read) begin
                        r_addr  <= bus.start_address_i;
                        r_end   <= bus.end_address_i;
                        r_state <= (bus.command_i == c_cmd_write) ? c_st_write : c_st_read;
                    end else if (bus.command_i == c_cmd_rsvd) begin
                        r_cmd_error <= 1'b1;
                    end
                end
                c_st_write: begin
                    if (w_wr_beat) begin
                        if (w_last) r_state <= c_st_done;
                        else        r_addr  <= r_addr + 1'b1;
                    end
                end
                c_st_read: begin
                    if (w_issue) begin
                        if (w_last) r_state <= c_st_drain;
                        else        r_addr  <= r_addr + 1'b1;
                    end
                end
                c_st_drain: begin
                    if (r_outstanding == 3'd0 && r_count == 3'd0) r_state <= c_st_done;
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    // Memory array is never reset; an aborted write burst simply stops
    always_ff @(posedge clk_i) begin
        if (w_wr_beat && !rst_i) r_mem[r_addr] <= bus.data_write_i;
    end

    // ------------------------------------------------------------------
    // Read pipeline: the first stage is the BRAM output register, the
    // FIFO write is the final stage, giving ReadLatency cycles in total.
    // ------------------------------------------------------------------
    generate
        if (ReadLatency == 1) begin : g_lat1
            assign w_push      = w_issue;
            assign w_push_data = w_mem_rdata;
        end else begin : g_pipe
            logic [ReadLatency-2:0] r_pv;
            logic [DataWidth-1:0]   r_pd [ReadLatency-1];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_issue;
                    for (int k = 1; k < ReadLatency - 1; k++) r_pv[k] <= r_pv[k-1];
                end
            end

            always_ff @(posedge clk_i) begin
                r_pd[0] <= w_mem_rdata;
                for (int k = 1; k < ReadLatency - 1; k++) r_pd[k] <= r_pd[k-1];
            end

            assign w_push      = r_pv[ReadLatency-2];
            assign w_push_data = r_pd[ReadLatency-2];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) r_outstanding <= 3'd0;
        else       r_outstanding <= r_outstanding + {2'b00, w_issue} - {2'b00, w_push};
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= 3'd0;
            r_rd_ptr <= 3'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i) r_fifo[r_wr_ptr] <= w_push_data;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cmd_ready_o        = (r_state == c_st_idle);
    assign bus.cmd_error_o        = r_cmd_error;
    assign bus.data_write_ready_o = (r_state == c_st_write);
    assign bus.data_read_valid_o  = (r_count != 3'd0);
    assign bus.data_read_o        = (r_count != 3'd0) ? r_fifo[r_rd_ptr] : '0;
    assign bus.task_finished_o    = (r_state == c_st_done);
    assign bus.mem_running_o      = (r_state != c_st_idle);

    // ------------------------------------------------------------------
    // Simulation checks
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i && bus.assert_on_i) begin
            assert (!(w_push && !w_pop && r_count == 3'(c_fifo_depth)));
            assert (!(w_pop && r_count == 3'd0));
            assert (ReadLatency >= 1 && ReadLatency <= 4);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aether_burst_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aether_burst_mem
//  Purpose  : Self-checking bench for aether_burst_mem. A word-level memory
//             model and an expected-beat queue predict every read beat.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aether_burst_mem;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aether_burst_mem_if #(.DataWidth(DW), .AddrWidth(AW)) ifc ();

    aether_burst_mem #(.DataWidth(DW), .AddrWidth(AW), .ReadLatency(RL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] model_mem [65536];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    int fin_count   = 0;
    int err_count   = 0;
    int first_valid = -1;
    int last_pop    = 0;
    int wr_acc      = 0;
    int wr_first    = 0;
    int wr_last     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.data_read_valid_o && first_valid < 0) first_valid = cyc;
            if (ifc.data_read_valid_o && ifc.data_read_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_extra: got beat %0h expected none", ifc.data_read_o);
                end else begin
                    if (ifc.data_read_o !== exp_q[0]) begin
                        errors++;
                        $display("FAIL rd_data: got %0h expected %0h", ifc.data_read_o, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got_q.push_back(ifc.data_read_o);
                last_pop = cyc;
            end
            if (!ifc.data_read_valid_o) chk("rd_idle_zero", 32'(ifc.data_read_o), 32'h0);
            chk("running_vs_ready", 32'(ifc.mem_running_o), 32'(!ifc.cmd_ready_o));
            if (ifc.task_finished_o) begin
                fin_count++;
                chk("finish_pending_beats", exp_q.size(), 0);
            end
            if (ifc.data_write_valid_i && ifc.data_write_ready_o) begin
                if (wr_acc == 0) wr_first = cyc;
                wr_last = cyc;
                wr_acc++;
            end
            if (ifc.cmd_error_o) err_count++;
        end
    end

    task automatic wait_finish(input int base);
        int tmo = 0;
        while (fin_count == base && tmo < 400) begin
            @(posedge clk); #1;
            tmo++;
        end
        if (tmo >= 400) begin
            checks++; errors++;
            $display("FAIL finish_timeout: got no task_finished expected pulse");
        end
    endtask

    // Burst write of n words: word i = first + i*step
    task automatic do_write(input logic [15:0] s, input logic [15:0] e,
                            input logic [15:0] first, input logic [15:0] step);
        int n, base, tmo;
        logic [15:0] a;
        n = int'(16'(e - s)) + 1;
        @(posedge clk); #1;
        chk("wr_cmd_ready", 32'(ifc.cmd_ready_o), 32'h1);
        ifc.command_i = 2'd1; ifc.start_address_i = s; ifc.end_address_i = e;
        wr_acc = 0; base = fin_count;
        @(posedge clk); #1;
        ifc.command_i = 2'd0;
        for (int i = 0; i < n; i++) begin
            a = s + 16'(i);
            ifc.data_write_i = first + 16'(i) * step;
            ifc.data_write_valid_i = 1'b1;
            model_mem[a] = ifc.data_write_i;
            tmo = 0;
            @(negedge clk);
            while (!ifc.data_write_ready_o && tmo < 50) begin @(negedge clk); tmo++; end
            if (tmo >= 50) begin
                checks++; errors++;
                $display("FAIL wr_ready_timeout: got ready 0 expected 1");
            end
            @(posedge clk); #1;
        end
        ifc.data_write_valid_i = 1'b0; ifc.data_write_i = '0;
        wait_finish(base);
        chk("wr_beats", wr_acc, n);
        chk("wr_consecutive", wr_last - wr_first, n - 1);
        @(posedge clk); #1;
        chk("wr_finish_once", fin_count, base + 1);
    endtask

    // mode 0: ready held; 1: ready 1,0,0 pattern; 2: ready held + WRITE cmds during the burst
    task automatic do_read(input logic [15:0] s, input logic [15:0] e, input int mode, output int t_cmd);
        int n, base, tmo, ebase;
        n = int'(16'(e - s)) + 1;
        @(posedge clk); #1;
        chk("rd_cmd_ready", 32'(ifc.cmd_ready_o), 32'h1);
        ifc.command_i = 2'd2; ifc.start_address_i = s; ifc.end_address_i = e;
        t_cmd = cyc; base = fin_count; ebase = err_count;
        first_valid = -1; got_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(model_mem[s + 16'(i)]);
        ifc.data_read_ready_i = (mode == 1) ? 1'b0 : 1'b1;
        tmo = 0;
        do begin
            @(posedge clk); #1;
            tmo++;
            ifc.command_i = (mode == 2 && tmo < 4) ? 2'd1 : 2'd0;
            if (mode == 2) begin ifc.start_address_i = 16'h0200; ifc.end_address_i = 16'h0203; end
            ifc.data_read_ready_i = (mode == 1) ? (((cyc - t_cmd) % 3) == 0) : 1'b1;
        end while (fin_count == base && tmo < 400);
        if (tmo >= 400) begin
            checks++; errors++;
            $display("FAIL rd_finish_timeout: got no task_finished expected pulse");
        end
        ifc.data_read_ready_i = 1'b1;
        chk("rd_beats", got_q.size(), n);
        if (mode == 2) chk("rd_no_error_busy", err_count, ebase);
        @(posedge clk); #1;
        chk("rd_finish_once", fin_count, base + 1);
    endtask

    int t;
    int base_f;
    int base_e;
    int tmo;

    initial begin
        ifc.command_i = 2'd0; ifc.start_address_i = '0; ifc.end_address_i = '0;
        ifc.data_write_i = '0; ifc.data_write_valid_i = 1'b0;
        ifc.data_read_ready_i = 1'b0; ifc.assert_on_i = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(ifc.cmd_ready_o), 32'h1);
        chk("rst_cmd_error", 32'(ifc.cmd_error_o), 32'h0);
        chk("rst_wr_ready",  32'(ifc.data_write_ready_o), 32'h0);
        chk("rst_rd_valid",  32'(ifc.data_read_valid_o), 32'h0);
        chk("rst_rd_data",   32'(ifc.data_read_o), 32'h0);
        chk("rst_finished",  32'(ifc.task_finished_o), 32'h0);
        chk("rst_running",   32'(ifc.mem_running_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic write then read, ready held
        do_write(16'h0010, 16'h0013, 16'hA000, 16'h0001);
        do_read(16'h0010, 16'h0013, 0, t);
        chk("basic_first_valid", first_valid, t + 1 + RL);
        chk("basic_beat_spacing", last_pop - first_valid, 3);
        chk("basic_d0", 32'(got_q[0]), 32'hA000);
        chk("basic_d1", 32'(got_q[1]), 32'hA001);
        chk("basic_d2", 32'(got_q[2]), 32'hA002);
        chk("basic_d3", 32'(got_q[3]), 32'hA003);

        // Backpressure
        do_read(16'h0010, 16'h0013, 1, t);
        chk("bp_d0", 32'(got_q[0]), 32'hA000);
        chk("bp_d3", 32'(got_q[3]), 32'hA003);

        // Wrap through address 0, fenced by sentinels
        do_write(16'hFFFD, 16'h0002, 16'h5555, 16'h0000);
        do_write(16'hFFFE, 16'h0001, 16'h0001, 16'h0001);
        do_read(16'hFFFD, 16'h0002, 0, t);
        chk("wrap_fffd", 32'(got_q[0]), 32'h5555);
        chk("wrap_fffe", 32'(got_q[1]), 32'h0001);
        chk("wrap_ffff", 32'(got_q[2]), 32'h0002);
        chk("wrap_0000", 32'(got_q[3]), 32'h0003);
        chk("wrap_0001", 32'(got_q[4]), 32'h0004);
        chk("wrap_0002", 32'(got_q[5]), 32'h5555);

        // Single-beat burst
        do_write(16'h0005, 16'h0005, 16'hBEEF, 16'h0000);
        do_read(16'h0005, 16'h0005, 0, t);
        chk("single_d0", 32'(got_q[0]), 32'hBEEF);

        // Reset during the second beat of a read
        @(posedge clk); #1;
        ifc.command_i = 2'd2; ifc.start_address_i = 16'h0010; ifc.end_address_i = 16'h0013;
        ifc.data_read_ready_i = 1'b1;
        base_f = fin_count; got_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[16'h0010 + 16'(i)]);
        @(posedge clk); #1;
        ifc.command_i = 2'd0;
        tmo = 0;
        while (got_q.size() < 1 && tmo < 50) begin @(posedge clk); #1; tmo++; end
        chk("rstmid_first_beat", got_q.size(), 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_cmd_ready", 32'(ifc.cmd_ready_o), 32'h1);
        chk("rstmid_rd_valid",  32'(ifc.data_read_valid_o), 32'h0);
        chk("rstmid_rd_data",   32'(ifc.data_read_o), 32'h0);
        chk("rstmid_running",   32'(ifc.mem_running_o), 32'h0);
        chk("rstmid_finished",  32'(ifc.task_finished_o), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("rstmid_no_finish", fin_count, base_f);
        do_read(16'h0010, 16'h0013, 0, t);
        chk("rstmid_re_d1", 32'(got_q[1]), 32'hA001);
        chk("rstmid_re_d3", 32'(got_q[3]), 32'hA003);

        // Reserved command in IDLE
        base_e = err_count;
        @(posedge clk); #1;
        ifc.command_i = 2'd3;
        @(posedge clk); #1;
        ifc.command_i = 2'd0;
        @(negedge clk);
        chk("err_pulse", 32'(ifc.cmd_error_o), 32'h1);
        chk("err_stays_idle", 32'(ifc.cmd_ready_o), 32'h1);
        @(negedge clk);
        chk("err_pulse_end", 32'(ifc.cmd_error_o), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("err_single", err_count, base_e + 1);

        // WRITE command during an active READ is ignored
        do_read(16'h0010, 16'h0013, 2, t);
        chk("busy_d0", 32'(got_q[0]), 32'hA000);
        chk("busy_d3", 32'(got_q[3]), 32'hA003);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
